// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
`timescale 1ns/1ps
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Destination info carried by every tracked stage.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } entry_t;

  // Source info carried only by the EX stage (for forwarding).
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } src_t;

  // True when entry e produces the value read through src; load_only
  // restricts the match to load instructions.
  function automatic logic entry_matches(input entry_t     e,
                                         input logic [4:0] src,
                                         input logic       uses,
                                         input logic       load_only);
    return e.valid & e.reg_write & (e.dest != REG_ZERO) & (e.dest == src)
           & uses & (~load_only | e.mem_read);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle.
`timescale 1ns/1ps
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_jump;
  logic             ex_jump_reg;
  logic             mem_branch_taken;
  logic             halt_req;
  logic             pc_enable;
  logic             if_id_enable;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  // Datapath side.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, id_jump, ex_jump_reg,
           mem_branch_taken, halt_req,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush,
           fwd_a_sel, fwd_b_sel, halted, stall_cycles, flush_events
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, id_jump, ex_jump_reg,
           mem_branch_taken, halt_req,
    output pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush,
           fwd_a_sel, fwd_b_sel, halted, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_tracker.sv
// Shadow copy of EX/MEM/WB destination info with flush-aware valid bits.
`timescale 1ns/1ps
module pipe_dest_tracker
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  input  logic [4:0] id_dest_i,
  input  logic       id_reg_write_i,
  input  logic       id_mem_read_i,
  input  logic       id_ex_flush_i,
  input  logic       ex_mem_flush_i,
  output logic [2:0] valid_o,        // {WB, MEM, EX}
  output logic       ex_load_use_o,  // EX load feeds an ID source
  output logic       any_match_id_o, // any stage feeds an ID source
  output logic       mem_fwd_a_o,
  output logic       mem_fwd_b_o,
  output logic       wb_fwd_a_o,
  output logic       wb_fwd_b_o
);

  entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  src_t   ex_src_q, ex_src_d;

  // Next-state of the shift chain; flushes clear only the valid bit.
  always_comb begin
    ex_d           = '{valid:     id_valid_i & ~id_ex_flush_i,
                       dest:      id_dest_i,
                       reg_write: id_reg_write_i,
                       mem_read:  id_mem_read_i};
    ex_src_d       = '{rs: id_rs_i, rt: id_rt_i,
                       uses_rs: id_uses_rs_i, uses_rt: id_uses_rt_i};
    mem_d          = ex_q;
    mem_d.valid    = ex_q.valid & ~ex_mem_flush_i;
    wb_d           = mem_q;
  end

  // Stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q     <= '0;
      ex_src_q <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else begin
      ex_q     <= ex_d;
      ex_src_q <= ex_src_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
    end
  end

  // Match outputs toward the ID and EX consumers.
  always_comb begin
    valid_o        = {wb_q.valid, mem_q.valid, ex_q.valid};
    ex_load_use_o  = entry_matches(ex_q,  id_rs_i, id_uses_rs_i, 1'b1)
                   | entry_matches(ex_q,  id_rt_i, id_uses_rt_i, 1'b1);
    any_match_id_o = entry_matches(ex_q,  id_rs_i, id_uses_rs_i, 1'b0)
                   | entry_matches(ex_q,  id_rt_i, id_uses_rt_i, 1'b0)
                   | entry_matches(mem_q, id_rs_i, id_uses_rs_i, 1'b0)
                   | entry_matches(mem_q, id_rt_i, id_uses_rt_i, 1'b0)
                   | entry_matches(wb_q,  id_rs_i, id_uses_rs_i, 1'b0)
                   | entry_matches(wb_q,  id_rt_i, id_uses_rt_i, 1'b0);
    mem_fwd_a_o    = entry_matches(mem_q, ex_src_q.rs, ex_src_q.uses_rs, 1'b0);
    mem_fwd_b_o    = entry_matches(mem_q, ex_src_q.rt, ex_src_q.uses_rt, 1'b0);
    wb_fwd_a_o     = entry_matches(wb_q,  ex_src_q.rs, ex_src_q.uses_rs, 1'b0);
    wb_fwd_b_o     = entry_matches(wb_q,  ex_src_q.rt, ex_src_q.uses_rt, 1'b0);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage MIPS pipeline sequencer: stalls, flushes, forwarding, debug halt.
`timescale 1ns/1ps
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter bit          FWD_ENABLE = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic [2:0]       trk_valid;
  logic             ex_load_use, any_match_id;
  logic             mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b;
  logic             hazard, stall_evt, flush_evt;
  logic             pc_en, ifid_en, ifid_fl, idex_fl, exmem_fl, halted;
  logic [1:0]       fwd_a, fwd_b;

  pipe_dest_tracker u_tracker (
    .clk_i          (clk),
    .rst_ni         (reset),
    .id_valid_i     (bus.id_valid),
    .id_rs_i        (bus.id_rs),
    .id_rt_i        (bus.id_rt),
    .id_uses_rs_i   (bus.id_uses_rs),
    .id_uses_rt_i   (bus.id_uses_rt),
    .id_dest_i      (bus.id_dest),
    .id_reg_write_i (bus.id_reg_write),
    .id_mem_read_i  (bus.id_mem_read),
    .id_ex_flush_i  (idex_fl),
    .ex_mem_flush_i (exmem_fl),
    .valid_o        (trk_valid),
    .ex_load_use_o  (ex_load_use),
    .any_match_id_o (any_match_id),
    .mem_fwd_a_o    (mem_fwd_a),
    .mem_fwd_b_o    (mem_fwd_b),
    .wb_fwd_a_o     (wb_fwd_a),
    .wb_fwd_b_o     (wb_fwd_b)
  );

  assign hazard = ex_load_use | (!FWD_ENABLE && any_match_id);

  // Operand forwarding selects; the younger MEM result wins over WB.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (FWD_ENABLE) begin
      if (mem_fwd_a)     fwd_a = FWD_MEM;
      else if (wb_fwd_a) fwd_a = FWD_WB;
      if (mem_fwd_b)     fwd_b = FWD_MEM;
      else if (wb_fwd_b) fwd_b = FWD_WB;
    end
  end

  // Sequencer next-state and stall/flush outputs.
  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    exmem_fl  = 1'b0;
    halted    = 1'b0;
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.halt_req) state_d = DRAIN;
        if (bus.mem_branch_taken) begin
          ifid_fl   = 1'b1;
          idex_fl   = 1'b1;
          exmem_fl  = 1'b1;
          flush_evt = 1'b1;
        end else if (bus.ex_jump_reg) begin
          ifid_fl   = 1'b1;
          idex_fl   = 1'b1;
          flush_evt = 1'b1;
        end else if (hazard) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_fl   = 1'b1;
          stall_evt = 1'b1;
        end else if (bus.id_jump) begin
          ifid_fl   = 1'b1;
          flush_evt = 1'b1;
        end
      end
      DRAIN: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_fl = 1'b1;
        if (!bus.halt_req)       state_d = RUN;
        else if (trk_valid == '0) state_d = HALTED;
        // Redirects already in flight must still land in the PC.
        if (bus.mem_branch_taken) begin
          pc_en     = 1'b1;
          ifid_fl   = 1'b1;
          exmem_fl  = 1'b1;
          flush_evt = 1'b1;
        end else if (bus.ex_jump_reg) begin
          pc_en     = 1'b1;
          ifid_fl   = 1'b1;
          flush_evt = 1'b1;
        end
      end
      HALTED: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        halted  = 1'b1;
        if (!bus.halt_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_evt && (stall_q != '1)) stall_d = stall_q + CNT_ONE;
    if (flush_evt && (flush_q != '1)) flush_d = flush_q + CNT_ONE;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_enable    = pc_en;
  assign bus.if_id_enable = ifid_en;
  assign bus.if_id_flush  = ifid_fl;
  assign bus.id_ex_flush  = idex_fl;
  assign bus.ex_mem_flush = exmem_fl;
  assign bus.fwd_a_sel    = fwd_a;
  assign bus.fwd_b_sel    = fwd_b;
  assign bus.halted       = halted;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: one forwarding controller, one stall-only controller
// with 2-bit counters, both fed the same ID-stage stimulus.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_jump, ex_jump_reg, mem_branch_taken, halt_req;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) b1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  b0 ();

  assign b1.id_valid = id_valid;         assign b0.id_valid = id_valid;
  assign b1.id_rs = id_rs;               assign b0.id_rs = id_rs;
  assign b1.id_rt = id_rt;               assign b0.id_rt = id_rt;
  assign b1.id_uses_rs = id_uses_rs;     assign b0.id_uses_rs = id_uses_rs;
  assign b1.id_uses_rt = id_uses_rt;     assign b0.id_uses_rt = id_uses_rt;
  assign b1.id_dest = id_dest;           assign b0.id_dest = id_dest;
  assign b1.id_reg_write = id_reg_write; assign b0.id_reg_write = id_reg_write;
  assign b1.id_mem_read = id_mem_read;   assign b0.id_mem_read = id_mem_read;
  assign b1.id_jump = id_jump;           assign b0.id_jump = id_jump;
  assign b1.ex_jump_reg = ex_jump_reg;   assign b0.ex_jump_reg = ex_jump_reg;
  assign b1.mem_branch_taken = mem_branch_taken;
  assign b0.mem_branch_taken = mem_branch_taken;
  assign b1.halt_req = halt_req;         assign b0.halt_req = halt_req;

  pipeline_hazard_ctrl #(.FWD_ENABLE(1'b1), .CNT_W(16)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  pipeline_hazard_ctrl #(.FWD_ENABLE(1'b0), .CNT_W(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_dest = 0; id_reg_write = 0; id_mem_read = 0;
    id_jump = 0; ex_jump_reg = 0; mem_branch_taken = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic [4:0] dest, input logic rw, input logic mr);
    nop();
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    nop();
    halt_req = 0;
    reset    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",     b1.pc_enable, 1);
    chk("rst_ifid",   b1.if_id_enable, 1);
    chk("rst_flush",  {b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush}, 0);
    chk("rst_fwd",    {b1.fwd_a_sel, b1.fwd_b_sel}, 0);
    chk("rst_halted", b1.halted, 0);
    chk("rst_stall",  b1.stall_cycles, 0);
    chk("rst_fevt",   b1.flush_events, 0);
    @(posedge clk); #1 reset = 1;

    // lw $t0 ; add $t1,$t0,$t2 -> one-cycle load-use stall, then WB forward
    instr(16, 0, 1, 0, 8, 1, 1);
    @(negedge clk); chk("lu_pre_pc", b1.pc_enable, 1);
    tick();
    instr(8, 10, 1, 1, 9, 1, 0);
    @(negedge clk);
    chk("lu_stall_pc",   b1.pc_enable, 0);
    chk("lu_stall_ifid", b1.if_id_enable, 0);
    chk("lu_stall_idex", b1.id_ex_flush, 1);
    tick();
    chk("lu_stall_cnt", b1.stall_cycles, 1);
    @(negedge clk);
    chk("lu_once_pc",   b1.pc_enable, 1);
    chk("lu_once_idex", b1.id_ex_flush, 0);
    tick();
    nop();
    @(negedge clk);
    chk("lu_fwd_a", b1.fwd_a_sel, 2'b01);
    chk("lu_fwd_b", b1.fwd_b_sel, 2'b00);
    repeat (4) tick();

    // add $t0 ; sub $t3,$t0,$t0 -> no stall, both operands from EX_MEM
    instr(16, 16, 1, 1, 8, 1, 0);
    tick();
    instr(8, 8, 1, 1, 11, 1, 0);
    @(negedge clk);
    chk("fw_nostall_pc",   b1.pc_enable, 1);
    chk("fw_nostall_idex", b1.id_ex_flush, 0);
    tick();
    nop();
    @(negedge clk);
    chk("fw_a_mem", b1.fwd_a_sel, 2'b10);
    chk("fw_b_mem", b1.fwd_b_sel, 2'b10);
    chk("fw_stall_cnt", b1.stall_cycles, 1);
    repeat (4) tick();

    // lw $0 ; read $0,$0 -> register zero never creates a dependency
    instr(16, 0, 1, 0, 0, 1, 1);
    tick();
    instr(0, 0, 1, 1, 9, 1, 0);
    @(negedge clk);
    chk("r0_pc",   b1.pc_enable, 1);
    chk("r0_idex", b1.id_ex_flush, 0);
    tick();
    nop();
    @(negedge clk);
    chk("r0_fwd", {b1.fwd_a_sel, b1.fwd_b_sel}, 0);
    repeat (4) tick();

    // Taken branch coincident with a load-use hazard
    instr(16, 0, 1, 0, 8, 1, 1);
    tick();
    instr(8, 10, 1, 1, 9, 1, 0);
    mem_branch_taken = 1;
    @(negedge clk);
    chk("br_flushes", {b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush}, 3'b111);
    chk("br_pc",      b1.pc_enable, 1);
    chk("br_ifid",    b1.if_id_enable, 1);
    tick();
    chk("br_fevt",  b1.flush_events, 1);
    chk("br_stall", b1.stall_cycles, 1);
    nop();
    @(negedge clk);
    chk("br_mem_invalid", b1.fwd_a_sel, 2'b00);
    tick();

    // jr in EX, then j in ID, then j under a load-use stall
    nop(); ex_jump_reg = 1;
    @(negedge clk);
    chk("jr_flushes", {b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush}, 3'b110);
    chk("jr_pc",      b1.pc_enable, 1);
    tick();
    chk("jr_fevt", b1.flush_events, 2);
    instr(0, 0, 0, 0, 0, 0, 0); id_jump = 1;
    @(negedge clk);
    chk("j_flushes", {b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush}, 3'b100);
    chk("j_pc",      b1.pc_enable, 1);
    tick();
    chk("j_fevt", b1.flush_events, 3);
    instr(16, 0, 1, 0, 8, 1, 1);
    tick();
    instr(8, 10, 1, 1, 9, 1, 0); id_jump = 1;
    @(negedge clk);
    chk("jstall_pc",      b1.pc_enable, 0);
    chk("jstall_flushes", {b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush}, 3'b010);
    tick();
    chk("jstall_fevt",  b1.flush_events, 3);
    chk("jstall_stall", b1.stall_cycles, 2);
    nop();
    repeat (4) tick();

    // Halt with three instructions in flight, then resume
    instr(16, 16, 1, 1, 9, 1, 0);  tick();
    instr(16, 16, 1, 1, 12, 1, 0); tick();
    instr(16, 16, 1, 1, 13, 1, 0); tick();
    nop(); halt_req = 1;
    @(negedge clk);
    chk("h_run_pc",     b1.pc_enable, 1);
    chk("h_run_halted", b1.halted, 0);
    tick();
    instr(16, 0, 1, 0, 8, 1, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("h_drain_ctl", {b1.pc_enable, b1.if_id_enable, b1.id_ex_flush}, 3'b001);
      chk("h_drain_halted", b1.halted, 0);
      tick();
    end
    @(negedge clk);
    chk("h_halted", b1.halted, 1);
    chk("h_halted_ctl",
        {b1.pc_enable, b1.if_id_enable, b1.if_id_flush, b1.id_ex_flush, b1.ex_mem_flush}, 0);
    tick();
    halt_req = 0;
    @(negedge clk);
    chk("h_still_halted", b1.halted, 1);
    tick();
    @(negedge clk);
    chk("h_resume_halted", b1.halted, 0);
    chk("h_resume_pc",     b1.pc_enable, 1);
    tick();
    instr(8, 10, 1, 1, 9, 1, 0);
    @(negedge clk);
    chk("h_held_in_ex_pc",   b1.pc_enable, 0);
    chk("h_held_in_ex_idex", b1.id_ex_flush, 1);
    tick();
    chk("h_stall_cnt", b1.stall_cycles, 3);

    // Reset asserted while draining
    halt_req = 1;
    @(negedge clk);
    chk("rd_run_pc", b1.pc_enable, 1);
    tick();
    @(negedge clk);
    chk("rd_drain_pc", b1.pc_enable, 0);
    #1 reset = 0;
    #1;
    chk("rd_pc",     b1.pc_enable, 1);
    chk("rd_ifid",   b1.if_id_enable, 1);
    chk("rd_idex",   b1.id_ex_flush, 0);
    chk("rd_halted", b1.halted, 0);
    chk("rd_stall",  b1.stall_cycles, 0);
    chk("rd_fevt",   b1.flush_events, 0);
    halt_req = 0;
    nop();
    @(posedge clk); #1 reset = 1;

    // Stall-only controller: add $t0 ; sub $t3,$t0,$t0 -> 3 stalls
    instr(16, 16, 1, 1, 8, 1, 0);
    @(negedge clk); chk("f0_pre_pc", b0.pc_enable, 1);
    tick();
    instr(8, 8, 1, 1, 11, 1, 0);
    @(negedge clk); chk("f0_stall1_pc", b0.pc_enable, 0);
    tick();
    @(negedge clk);
    chk("f0_stall2_pc", b0.pc_enable, 0);
    chk("f0_fwd",       {b0.fwd_a_sel, b0.fwd_b_sel}, 0);
    tick();
    @(negedge clk); chk("f0_stall3_pc", b0.pc_enable, 0);
    tick();
    @(negedge clk);
    chk("f0_issue_pc",  b0.pc_enable, 1);
    chk("f0_stall_cnt", b0.stall_cycles, 3);
    tick();
    instr(11, 0, 1, 0, 12, 1, 0);
    @(negedge clk); chk("f0_stall4_pc", b0.pc_enable, 0);
    tick();
    chk("f0_saturate", b0.stall_cycles, 3);
    nop();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
